// File: rtl/procyon_fifo_ctrl.sv
// procyon_fifo_ctrl
// Pointer and flow-control sequencer that runs an external dual-port RAM
// (sync write, async read) as a synchronous FIFO with valid/ready on both sides.
// Optional feature macro: PROCYON_FIFO_BYPASS_EN. When defined, an empty FIFO
// forwards enqueue data straight to the dequeue side in the same cycle.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// exactly when valid && ready are both high in the cycle before that edge.
// Valid and ready are combinational from the pointers and flush only.
// The bypass path is the one exception: there dequeue valid/data also
// follow the enqueue inputs. The producer must hold valid/data until it
// sees ready. The consumer may drop ready at any time.

module procyon_fifo_ctrl #(
    parameter int OPTN_DATA_WIDTH = 8,
    parameter int OPTN_FIFO_DEPTH = 8,
    parameter int FIFO_IDX_WIDTH  = $clog2(OPTN_FIFO_DEPTH)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_fifo_flush,
    input  logic                       i_fifo_enq_valid,
    input  logic [OPTN_DATA_WIDTH-1:0] i_fifo_enq_data,
    output logic                       o_fifo_enq_ready,
    output logic                       o_fifo_deq_valid,
    output logic [OPTN_DATA_WIDTH-1:0] o_fifo_deq_data,
    input  logic                       i_fifo_deq_ready,
    output logic [FIFO_IDX_WIDTH:0]    o_fifo_count,
    output logic                       o_fifo_full,
    output logic                       o_fifo_empty,
    output logic                       o_ram_wr_en,
    output logic [FIFO_IDX_WIDTH-1:0]  o_ram_wr_addr,
    output logic [OPTN_DATA_WIDTH-1:0] o_ram_wr_data,
    output logic                       o_ram_rd_en,
    output logic [FIFO_IDX_WIDTH-1:0]  o_ram_rd_addr,
    input  logic [OPTN_DATA_WIDTH-1:0] i_ram_rd_data
);

    localparam int PTR_W = FIFO_IDX_WIDTH + 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic empty;
    logic full;
    logic head_valid;
    logic bypass;
    logic bypass_take;
    logic enq_fire;
    logic deq_fire;
    logic ram_wr_en;

    // Status and handshake decode from the current pointers and flush.
    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[FIFO_IDX_WIDTH-1:0] == rd_ptr_q[FIFO_IDX_WIDTH-1:0]) &&
                      (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
        head_valid  = !empty && !i_fifo_flush;
`ifdef PROCYON_FIFO_BYPASS_EN
        bypass      = empty && i_fifo_enq_valid && !i_fifo_flush;
`else
        bypass      = 1'b0;
`endif
        // A bypassed entry that is consumed at once never touches the RAM.
        bypass_take = bypass && i_fifo_deq_ready;

        o_fifo_enq_ready = !full && !i_fifo_flush;
        o_fifo_deq_valid = head_valid || bypass;

        enq_fire  = i_fifo_enq_valid && o_fifo_enq_ready;
        deq_fire  = o_fifo_deq_valid && i_fifo_deq_ready;
        ram_wr_en = enq_fire && !bypass_take;

        if (bypass) begin
            o_fifo_deq_data = i_fifo_enq_data;
        end else if (head_valid) begin
            o_fifo_deq_data = i_ram_rd_data;
        end else begin
            o_fifo_deq_data = '0;
        end

        o_fifo_count  = wr_ptr_q - rd_ptr_q;
        o_fifo_full   = full;
        o_fifo_empty  = empty;

        o_ram_wr_en   = ram_wr_en;
        o_ram_wr_addr = wr_ptr_q[FIFO_IDX_WIDTH-1:0];
        o_ram_wr_data = i_fifo_enq_data;
        o_ram_rd_en   = o_fifo_deq_valid;
        o_ram_rd_addr = rd_ptr_q[FIFO_IDX_WIDTH-1:0];
    end

    // Next-pointer logic: flush clears both, otherwise each advances on its own transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (ram_wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            // A bypass transfer leaves the read pointer alone; only real heads pop.
            if (deq_fire && !bypass) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers; reset discards all entries asynchronously.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule
